// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// Frame-level UART transmitter. Each frame is one start bit (0), DATA_WIDTH
// payload bits LSB first, an optional parity bit, and one or two stop bits (1).
// One bit is sent per clk cycle; no baud divider is applied here.
//
// Ports:
//   clk         single clock for all sequential logic
//   rst         asynchronous active-low reset
//   P_DATA      parallel payload, sampled on acceptance
//   Data_Valid  request to send P_DATA
//   PAR_EN      parity bit enable, sampled on acceptance
//   PAR_TYP     0 = even parity, 1 = odd parity, sampled on acceptance
//   STOP2       0 = one stop bit, 1 = two stop bits, sampled on acceptance
//   TX_OUT      serial line, idle high
//   busy        high while a frame is on the line
//   frame_done  one-cycle pulse in the final stop-bit cycle
//   dbg_state   current FSM state encoding (state_e), for observation only
//
// Handshake: Data_Valid is a request with no ready output. It is accepted on a
// clk edge only while the FSM is in IDLE or in the final STOP cycle (the cycle
// where frame_done is high); at every other edge it is ignored. The sender
// either holds Data_Valid until it sees frame_done / busy low, or streams
// frames back to back by keeping it high.
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_done,
    output logic [2:0]            dbg_state
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q,   stop2_d;

    logic stop_last;
    logic accept;

    // The counter is reused in STOP to tell the first of two stop bits from
    // the second one.
    assign stop_last = (state_q == STOP) && (!stop2_q || (cnt_q == CNT_W'(1)));
    assign accept    = Data_Valid && ((state_q == IDLE) || stop_last);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;

        if (accept) begin
            state_d   = START;
            cnt_d     = '0;
            shift_d   = P_DATA;
            par_en_d  = PAR_EN;
            // The parity bit is resolved at acceptance, so only a registered
            // value reaches TX_OUT and the payload can be shifted away freely.
            par_bit_d = (^P_DATA) ^ PAR_TYP;
            stop2_d   = STOP2;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                START: begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    cnt_d   = '0;
                end
                STOP: begin
                    if (stop_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode: registered state, counter and shift register only
    // -------------------------------------------------------------------------
    always_comb begin
        TX_OUT     = 1'b1;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            START: begin
                TX_OUT = 1'b0;
                busy   = 1'b1;
            end
            DATA: begin
                TX_OUT = shift_q[0];
                busy   = 1'b1;
            end
            PARITY: begin
                TX_OUT = par_bit_q;
                busy   = 1'b1;
            end
            STOP: begin
                busy       = 1'b1;
                frame_done = stop_last;
            end
            default: begin
                TX_OUT     = 1'b1;
                busy       = 1'b0;
                frame_done = 1'b0;
            end
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Directed bench for uart_tx_ctrl. Two instances share clk and rst: an 8-bit
// one for most scenarios and a 5-bit one for the narrow-payload case.
// Inputs are driven and outputs sampled on the falling clk edge; cycle 1 of a
// frame is the first falling edge after the accepting rising edge.
// Captured vectors hold cycle k of the frame in bit k-1.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  logic       clk;
  logic       rst;

  logic [7:0] p_data8;
  logic       dv8, par_en8, par_typ8, stop2_8;
  logic       tx8, busy8, fd8;
  logic [2:0] dbg8;

  logic [4:0] p_data5;
  logic       dv5, par_en5, par_typ5, stop2_5;
  logic       tx5, busy5, fd5;
  logic [2:0] dbg5;

  int tests_run;
  int tests_failed;

  logic [31:0] tx_cap, bz_cap, fd_cap;

  uart_tx_ctrl #(.DATA_WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (p_data8),
    .Data_Valid (dv8),
    .PAR_EN     (par_en8),
    .PAR_TYP    (par_typ8),
    .STOP2      (stop2_8),
    .TX_OUT     (tx8),
    .busy       (busy8),
    .frame_done (fd8),
    .dbg_state  (dbg8)
  );

  uart_tx_ctrl #(.DATA_WIDTH(5)) u_dut5 (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (p_data5),
    .Data_Valid (dv5),
    .PAR_EN     (par_en5),
    .PAR_TYP    (par_typ5),
    .STOP2      (stop2_5),
    .TX_OUT     (tx5),
    .busy       (busy5),
    .frame_done (fd5),
    .dbg_state  (dbg5)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Presents one Data_Valid pulse on the 8-bit DUT; returns at cycle 1.
  task automatic start_frame8(input logic [7:0] data, input logic pe,
                              input logic pt, input logic s2);
    @(negedge clk);
    p_data8  = data;
    par_en8  = pe;
    par_typ8 = pt;
    stop2_8  = s2;
    dv8      = 1'b1;
    @(negedge clk);
    dv8      = 1'b0;
  endtask

  // Samples n consecutive cycles starting at the current falling edge.
  task automatic capture(input int which, input int n,
                         output logic [31:0] tx, output logic [31:0] bz,
                         output logic [31:0] fd);
    tx = '0;
    bz = '0;
    fd = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (which == 0) begin
        tx[i] = tx8;
        bz[i] = busy8;
        fd[i] = fd8;
      end else begin
        tx[i] = tx5;
        bz[i] = busy5;
        fd[i] = fd5;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    #2;
    tests_run++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || fd8 !== 1'b0 || dbg8 !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: tx=%b busy=%b fd=%b state=%0d, expected 1 0 0 0",
               tx8, busy8, fd8, dbg8);
    end
    tests_run++;
    if (tx5 !== 1'b1 || busy5 !== 1'b0 || fd5 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs_w5: tx=%b busy=%b fd=%b, expected 1 0 0",
               tx5, busy5, fd5);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: tx=%b busy=%b, expected 1 0", tx8, busy8);
    end
  endtask

  task automatic test_even_parity();
    start_frame8(8'hA5, 1'b1, 1'b0, 1'b0);
    capture(0, 11, tx_cap, bz_cap, fd_cap);
    tests_run++;
    if (tx_cap[10:0] !== {1'b1, 1'b0, 8'hA5, 1'b0}) begin
      tests_failed++;
      $display("FAIL even_par_tx: got %b expected %b", tx_cap[10:0],
               {1'b1, 1'b0, 8'hA5, 1'b0});
    end
    tests_run++;
    if (bz_cap[10:0] !== 11'h7FF || fd_cap[10:0] !== 11'h400) begin
      tests_failed++;
      $display("FAIL even_par_busy_done: busy %b done %b expected %b %b",
               bz_cap[10:0], fd_cap[10:0], 11'h7FF, 11'h400);
    end
    @(negedge clk);
    tests_run++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || fd8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL even_par_end: tx=%b busy=%b fd=%b expected 1 0 0", tx8, busy8, fd8);
    end
  endtask

  task automatic test_odd_parity_stop2();
    start_frame8(8'hA5, 1'b1, 1'b1, 1'b1);
    capture(0, 12, tx_cap, bz_cap, fd_cap);
    tests_run++;
    if (tx_cap[11:0] !== {2'b11, 1'b1, 8'hA5, 1'b0}) begin
      tests_failed++;
      $display("FAIL odd_stop2_tx: got %b expected %b", tx_cap[11:0],
               {2'b11, 1'b1, 8'hA5, 1'b0});
    end
    tests_run++;
    if (bz_cap[11:0] !== 12'hFFF || fd_cap[11:0] !== 12'h800) begin
      tests_failed++;
      $display("FAIL odd_stop2_busy_done: busy %b done %b expected %b %b",
               bz_cap[11:0], fd_cap[11:0], 12'hFFF, 12'h800);
    end
    @(negedge clk);
    tests_run++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL odd_stop2_end: tx=%b busy=%b expected 1 0", tx8, busy8);
    end
  endtask

  task automatic test_no_parity();
    start_frame8(8'h00, 1'b0, 1'b0, 1'b0);
    capture(0, 10, tx_cap, bz_cap, fd_cap);
    tests_run++;
    if (tx_cap[9:0] !== {1'b1, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL no_par_tx: got %b expected %b", tx_cap[9:0], {1'b1, 8'h00, 1'b0});
    end
    tests_run++;
    if (bz_cap[9:0] !== 10'h3FF || fd_cap[9:0] !== 10'h200) begin
      tests_failed++;
      $display("FAIL no_par_busy_done: busy %b done %b expected %b %b",
               bz_cap[9:0], fd_cap[9:0], 10'h3FF, 10'h200);
    end
    @(negedge clk);
    tests_run++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_par_end: tx=%b busy=%b expected 1 0", tx8, busy8);
    end
  endtask

  // 8'h07 has three ones: even parity gives 1, odd parity gives 0.
  task automatic test_parity_odd_count();
    start_frame8(8'h07, 1'b1, 1'b0, 1'b0);
    capture(0, 11, tx_cap, bz_cap, fd_cap);
    tests_run++;
    if (tx_cap[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0}) begin
      tests_failed++;
      $display("FAIL par07_even_tx: got %b expected %b", tx_cap[10:0],
               {1'b1, 1'b1, 8'h07, 1'b0});
    end
    start_frame8(8'h07, 1'b1, 1'b1, 1'b0);
    capture(0, 11, tx_cap, bz_cap, fd_cap);
    tests_run++;
    if (tx_cap[10:0] !== {1'b1, 1'b0, 8'h07, 1'b0}) begin
      tests_failed++;
      $display("FAIL par07_odd_tx: got %b expected %b", tx_cap[10:0],
               {1'b1, 1'b0, 8'h07, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] txv, bzv, fdv;
    txv = '0;
    bzv = '0;
    fdv = '0;
    @(negedge clk);
    p_data8  = 8'h3C;
    par_en8  = 1'b0;
    par_typ8 = 1'b0;
    stop2_8  = 1'b0;
    dv8      = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      txv[i] = tx8;
      bzv[i] = busy8;
      fdv[i] = fd8;
      if (i == 9)  p_data8 = 8'hC3;   // final stop cycle of the first frame
      if (i == 10) dv8 = 1'b0;
    end
    tests_run++;
    if (txv !== {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_tx: got %b expected %b", txv,
               {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0});
    end
    tests_run++;
    if (bzv !== 20'hFFFFF) begin
      tests_failed++;
      $display("FAIL b2b_busy: got %b expected %b", bzv, 20'hFFFFF);
    end
    tests_run++;
    if (fdv !== 20'h80200) begin
      tests_failed++;
      $display("FAIL b2b_done: got %b expected %b", fdv, 20'h80200);
    end
    @(negedge clk);
    tests_run++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: tx=%b busy=%b expected 1 0", tx8, busy8);
    end
  endtask

  task automatic test_mid_frame_changes();
    logic [10:0] txv;
    txv = '0;
    start_frame8(8'hA5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      txv[i] = tx8;
      if (i >= 2 && i <= 5) begin
        p_data8  = (i[0]) ? 8'h5A : 8'hFF;
        par_en8  = 1'b0;
        par_typ8 = 1'b1;
        stop2_8  = 1'b1;
        dv8      = i[0];
      end
      if (i == 6) dv8 = 1'b0;
    end
    tests_run++;
    if (txv !== {1'b1, 1'b0, 8'hA5, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_frame_tx: got %b expected %b", txv, {1'b1, 1'b0, 8'hA5, 1'b0});
    end
    @(negedge clk);
    tests_run++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_frame_end: tx=%b busy=%b expected 1 0", tx8, busy8);
    end
  endtask

  task automatic test_reset_mid_frame();
    start_frame8(8'hA5, 1'b1, 1'b0, 1'b0);
    capture(0, 5, tx_cap, bz_cap, fd_cap);
    // Cycle 5 is data bit 3 of 8'hA5, which is 0.
    tests_run++;
    if (tx_cap[4:0] !== 5'b01010) begin
      tests_failed++;
      $display("FAIL pre_reset_tx: got %b expected %b", tx_cap[4:0], 5'b01010);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || fd8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort: tx=%b busy=%b fd=%b expected 1 0 0", tx8, busy8, fd8);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
        tests_failed++;
        $display("FAIL post_reset_idle cycle %0d: tx=%b busy=%b expected 1 0", i, tx8, busy8);
      end
    end
  endtask

  task automatic test_width5();
    @(negedge clk);
    p_data5  = 5'b10110;
    par_en5  = 1'b1;
    par_typ5 = 1'b0;
    stop2_5  = 1'b0;
    dv5      = 1'b1;
    @(negedge clk);
    dv5      = 1'b0;
    capture(1, 8, tx_cap, bz_cap, fd_cap);
    tests_run++;
    if (tx_cap[7:0] !== 8'b11101100) begin
      tests_failed++;
      $display("FAIL w5_tx: got %b expected %b", tx_cap[7:0], 8'b11101100);
    end
    tests_run++;
    if (bz_cap[7:0] !== 8'hFF || fd_cap[7:0] !== 8'h80) begin
      tests_failed++;
      $display("FAIL w5_busy_done: busy %b done %b expected %b %b",
               bz_cap[7:0], fd_cap[7:0], 8'hFF, 8'h80);
    end
    @(negedge clk);
    tests_run++;
    if (tx5 !== 1'b1 || busy5 !== 1'b0) begin
      tests_failed++;
      $display("FAIL w5_end: tx=%b busy=%b expected 1 0", tx5, busy5);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    p_data8  = '0;
    dv8      = 1'b0;
    par_en8  = 1'b0;
    par_typ8 = 1'b0;
    stop2_8  = 1'b0;
    p_data5  = '0;
    dv5      = 1'b0;
    par_en5  = 1'b0;
    par_typ5 = 1'b0;
    stop2_5  = 1'b0;
    rst      = 1'b0;

    test_reset();
    test_even_parity();
    test_odd_parity_stop2();
    test_no_parity();
    test_parity_odd_count();
    test_back_to_back();
    test_mid_frame_changes();
    test_reset_mid_frame();
    test_width5();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, payload bits per frame; legal range 5..16.
REQ-002 The block SHALL have port clk, input, 1, single clock for all sequential logic.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port P_DATA, input, DATA_WIDTH, parallel payload.
REQ-005 The block SHALL have port Data_Valid, input, 1, request to send P_DATA.
REQ-006 The block SHALL have port PAR_EN, input, 1, parity bit enable.
REQ-007 The block SHALL have port PAR_TYP, input, 1, 0 = even parity, 1 = odd parity.
REQ-008 The block SHALL have port STOP2, input, 1, 0 = one stop bit, 1 = two stop bits.
REQ-009 The block SHALL have port TX_OUT, output, 1, serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1, high while a frame is on the line.
REQ-011 The block SHALL have port frame_done, output, 1, one-cycle pulse in the final stop-bit cycle.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; any unencoded state SHALL go to IDLE with TX_OUT=1 and busy=0.
REQ-013 Acceptance: Data_Valid=1 at a clk edge while in IDLE, or in the final STOP cycle, SHALL latch P_DATA, PAR_EN, PAR_TYP and STOP2 and move to START.
REQ-014 Data_Valid SHALL be ignored in START, DATA, PARITY and non-final STOP cycles; input changes mid-frame SHALL NOT affect the frame in progress.
REQ-015 START SHALL last 1 cycle with TX_OUT=0, then go to DATA.
REQ-016 DATA SHALL last exactly DATA_WIDTH cycles, sending latched bits LSB first; an internal bit counter of width clog2(DATA_WIDTH) SHALL count 0..DATA_WIDTH-1.
REQ-017 After the last data bit, the FSM SHALL go to PARITY if latched PAR_EN=1, else to STOP.
REQ-018 PARITY SHALL last 1 cycle; TX_OUT SHALL be the XOR of all latched data bits when PAR_TYP=0, and its inverse when PAR_TYP=1.
REQ-019 STOP SHALL last 1 cycle (STOP2=0) or 2 cycles (STOP2=1) with TX_OUT=1.
REQ-020 From the final STOP cycle, the FSM SHALL go to START on acceptance (no idle gap), else to IDLE.
REQ-021 Frame length SHALL be 1 + DATA_WIDTH + PAR_EN + (1 + STOP2) cycles.
REQ-022 TX_OUT, busy and frame_done SHALL be decoded only from registered state, counter and shift register; they SHALL NOT have a combinational path from inputs.
REQ-023 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE; it SHALL stay 1 across back-to-back frames.
REQ-024 frame_done SHALL be 1 only in the final STOP cycle of each frame.

Reset
REQ-025 While rst=0, the block SHALL hold state=IDLE, counter=0, shift and config registers=0, TX_OUT=1, busy=0 and frame_done=0, with the outputs taking these values immediately and independent of clk.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further bits sent; after release the block SHALL wait in IDLE for a new Data_Valid.

Verification
REQ-027 DATA_WIDTH=8, P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, STOP2=0, single Data_Valid pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; busy=1 for those 11 cycles; frame_done on cycle 11.
REQ-028 Same stimulus with PAR_TYP=1, STOP2=1 -> parity bit 1, two stop cycles, frame length 12.
REQ-029 PAR_EN=0, P_DATA=8'h00 -> sequence 0, eight 0s, 1; frame length 10; no parity cycle.
REQ-030 Data_Valid held high with P_DATA=8'h3C then 8'hC3 presented at the final stop cycle -> second START immediately follows the stop bit; busy never drops; frame_done pulses twice.
REQ-031 P_DATA, PAR_EN and Data_Valid toggled during DATA -> transmitted frame unchanged.
REQ-032 rst asserted during the 4th data bit -> TX_OUT=1 and busy=0 at once; after release, TX_OUT stays 1 until the next Data_Valid.
REQ-033 DATA_WIDTH=5, P_DATA=5'b10110, PAR_EN=1, PAR_TYP=0 -> sequence 0,0,1,1,0,1,1,1; frame length 8.
